// File: rtl/frame_prev_fetch_pkg.sv
// Shared types and helpers for the previous-frame store controller.
// Provides the capture state enum and the frame-size helper.
package frame_prev_fetch_pkg;

    typedef enum logic {
        WAIT_VS = 1'b0,
        FRAME   = 1'b1
    } state_e;

    function automatic int unsigned frame_pix(
        input int unsigned w,
        input int unsigned h
    );
        return w * h;
    endfunction

endpackage

// File: rtl/frame_prev_fetch.sv
// Previous-frame store controller: writes current luma into one RAM bank,
// reads the co-located previous-frame sample from the other bank.
// Ports:
//   sys_clk, sys_rst           clock, synchronous active-high reset
//   per_frame_vsync/href/clken frame sync, line valid, pixel strobe
//   per_img_Y                  current luma
//   mem_wr_*/mem_rd_*          external dual-port RAM, {bank, index} addressing
//   mem_rd_data                RAM read data, one-cycle latency
//   YCbCr_img_Y_pre, pre_valid previous-frame luma, one cycle after the strobe
//   frame_err                  pulse when a closed frame had the wrong size
module frame_prev_fetch
    import frame_prev_fetch_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = 19
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [7:0]       per_img_Y,
    output logic             mem_wr_en,
    output logic [PIX_W:0]   mem_wr_addr,
    output logic [7:0]       mem_wr_data,
    output logic             mem_rd_en,
    output logic [PIX_W:0]   mem_rd_addr,
    input  logic [7:0]       mem_rd_data,
    output logic [7:0]       YCbCr_img_Y_pre,
    output logic             pre_valid,
    output logic             frame_err
);

    localparam int unsigned FRAME_PIX = frame_pix(IMG_W, IMG_H);
    localparam int unsigned CNT_W     = PIX_W + 1;
    // Counter is one bit wider than the index so it can sit at FRAME_PIX
    // even when FRAME_PIX == 2**PIX_W.
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_PIX);

    state_e           state_q;
    logic             cur_bank_q;
    logic             prev_ok_q;
    logic             ovf_q;
    logic             vs_q;
    logic             pre_valid_q;
    logic             frame_err_q;
    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] pix_cnt_d;

    logic pix_strb;
    logic vs_rise;
    logic full;
    logic acc;
    logic close_ok;

    assign pix_strb = per_frame_clken & per_frame_href & ~per_frame_vsync;
    assign vs_rise  = per_frame_vsync & ~vs_q;
    assign full     = (pix_cnt_q == FULL_CNT);
    assign acc      = pix_strb & (state_q == FRAME) & ~full;
    assign close_ok = full & ~ovf_q;
    assign pix_cnt_d = pix_cnt_q + CNT_W'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= WAIT_VS;
            cur_bank_q  <= 1'b0;
            prev_ok_q   <= 1'b0;
            ovf_q       <= 1'b0;
            vs_q        <= 1'b0;
            pre_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            pix_cnt_q   <= '0;
        end else begin
            vs_q        <= per_frame_vsync;
            frame_err_q <= 1'b0;
            pre_valid_q <= acc & prev_ok_q;
            unique case (state_q)
                WAIT_VS: begin
                    if (vs_rise) begin
                        state_q   <= FRAME;
                        pix_cnt_q <= '0;
                        prev_ok_q <= 1'b0;
                        ovf_q     <= 1'b0;
                    end
                end
                FRAME: begin
                    if (vs_rise) begin
                        // Only a complete frame becomes the reference.
                        cur_bank_q  <= cur_bank_q ^ close_ok;
                        prev_ok_q   <= close_ok;
                        frame_err_q <= ~close_ok;
                        pix_cnt_q   <= '0;
                        ovf_q       <= 1'b0;
                    end else if (acc) begin
                        pix_cnt_q <= pix_cnt_d;
                    end else if (pix_strb & full) begin
                        ovf_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign mem_wr_en   = acc;
    assign mem_rd_en   = acc;
    assign mem_wr_addr = {cur_bank_q, pix_cnt_q[PIX_W-1:0]};
    assign mem_rd_addr = {~cur_bank_q, pix_cnt_q[PIX_W-1:0]};
    assign mem_wr_data = per_img_Y;

    assign pre_valid       = pre_valid_q;
    assign frame_err       = frame_err_q;
    assign YCbCr_img_Y_pre = pre_valid_q ? mem_rd_data : 8'd0;

endmodule

// File: tb/tb_frame_prev_fetch.sv
// Self-checking bench for frame_prev_fetch (4x2 frames).
// Directed table, hand sequences and random frames against a frame-level model.
module tb_frame_prev_fetch;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int PW = 3;
    localparam int FP = W * H;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic       per_frame_clken = 1'b0;
    logic [7:0] per_img_Y = 8'd0;
    logic       mem_wr_en;
    logic [PW:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic       mem_rd_en;
    logic [PW:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'd0;
    logic [7:0] YCbCr_img_Y_pre;
    logic       pre_valid;
    logic       frame_err;

    always #5 sys_clk = ~sys_clk;

    frame_prev_fetch #(
        .IMG_W(W),
        .IMG_H(H),
        .PIX_W(PW)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .per_img_Y       (per_img_Y),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_addr     (mem_wr_addr),
        .mem_wr_data     (mem_wr_data),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .YCbCr_img_Y_pre (YCbCr_img_Y_pre),
        .pre_valid       (pre_valid),
        .frame_err       (frame_err)
    );

    // External dual-port RAM, one-cycle synchronous read
    logic [7:0] ram [2*FP];
    always @(posedge sys_clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Frame-level reference: pixels of the open frame, the last complete
    // frame, and how many complete frames have closed (bank parity).
    bit         m_sync;
    bit         m_ref_ok;
    bit         m_bank;
    bit         m_over;
    bit         m_vs_prev;
    logic [7:0] m_cur [$];
    logic [7:0] m_ref [FP];
    bit         e_pv;
    logic [7:0] e_y;
    bit         e_err;

    task automatic model_reset();
        m_sync = 0; m_ref_ok = 0; m_bank = 0; m_over = 0; m_vs_prev = 0;
        m_cur.delete();
        e_pv = 0; e_y = 8'd0; e_err = 0;
    endtask

    typedef struct {
        logic       rst, vs, href, ck;
        logic [7:0] y;
        logic       wr;
        logic [3:0] addr;
        logic       pv;
        logic [7:0] yp;
        logic       err;
    } tv_t;

    tv_t tbl [24];
    tv_t nul;

    function automatic tv_t mk(input logic r, v, h, c, input logic [7:0] y,
                               input logic wr, input logic [3:0] a,
                               input logic pv, input logic [7:0] yp,
                               input logic err);
        tv_t t;
        t.rst = r; t.vs = v; t.href = h; t.ck = c; t.y = y;
        t.wr = wr; t.addr = a; t.pv = pv; t.yp = yp; t.err = err;
        return t;
    endfunction

    task automatic step(input logic r, v, h, c, input logic [7:0] y,
                        input bit use_tbl, input tv_t t);
        bit         valid, rise, acc;
        int         idx;
        logic [3:0] ea;
        sys_rst = r; per_frame_vsync = v; per_frame_href = h;
        per_frame_clken = c; per_img_Y = y;
        @(negedge sys_clk);
        valid = c & h & ~v;
        rise  = v & ~m_vs_prev;
        idx   = m_cur.size();
        acc   = m_sync && valid && (idx < FP);
        ea    = {m_bank, 3'(idx)};
        if (use_tbl) begin
            chk("tbl_wr_en", mem_wr_en, t.wr);
            chk("tbl_rd_en", mem_rd_en, t.wr);
            if (t.wr) begin
                chk("tbl_wr_addr", mem_wr_addr, t.addr);
                chk("tbl_rd_addr", mem_rd_addr, t.addr ^ 4'h8);
                chk("tbl_wr_data", mem_wr_data, t.y);
            end
            chk("tbl_pre_valid", pre_valid, t.pv);
            chk("tbl_y_pre", YCbCr_img_Y_pre, t.yp);
            chk("tbl_frame_err", frame_err, t.err);
        end else begin
            chk("wr_en", mem_wr_en, acc);
            chk("rd_en", mem_rd_en, acc);
            if (acc) begin
                chk("wr_addr", mem_wr_addr, ea);
                chk("rd_addr", mem_rd_addr, ea ^ 4'h8);
                chk("wr_data", mem_wr_data, y);
            end
            chk("pre_valid", pre_valid, e_pv);
            chk("y_pre", YCbCr_img_Y_pre, e_y);
            chk("frame_err", frame_err, e_err);
        end
        @(posedge sys_clk);
        if (r) begin
            model_reset();
        end else begin
            e_pv  = acc && m_ref_ok;
            e_y   = e_pv ? m_ref[idx] : 8'd0;
            e_err = m_sync && rise && !(idx == FP && !m_over);
            if (rise && m_sync) begin
                if (idx == FP && !m_over) begin
                    for (int i = 0; i < FP; i++) m_ref[i] = m_cur[i];
                    m_ref_ok = 1;
                    m_bank   = ~m_bank;
                end else begin
                    m_ref_ok = 0;
                end
                m_cur.delete();
                m_over = 0;
            end else if (rise) begin
                m_sync   = 1;
                m_ref_ok = 0;
                m_cur.delete();
                m_over   = 0;
            end else if (acc) begin
                m_cur.push_back(y);
            end else if (m_sync && valid) begin
                m_over = 1;
            end
            m_vs_prev = v;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'd0, 0, nul);
    endtask

    task automatic frame(input int n, input bit gaps);
        step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom), 0, nul);
        if (gaps && $urandom_range(0, 3) == 0) step(0, 1, 0, 0, 8'd0, 0, nul);
        step(0, 0, 0, 0, 8'd0, 0, nul);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2))
                    step(0, 0, 1'b0, 1'($urandom_range(0, 1)),
                         8'($urandom), 0, nul);
            end
            step(0, 0, 1, 1, 8'($urandom), 0, nul);
        end
        idle(2);
    endtask

    initial begin
        nul = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = mk(1, 0, 0, 0, 8'd0,  0, 4'd0, 0, 8'd0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 8'd0,  0, 4'd0, 0, 8'd0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 8'd99, 0, 4'd0, 0, 8'd0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 8'd10, 1, 4'd0, 0, 8'd0, 0);
        tbl[4]  = mk(0, 0, 1, 1, 8'd11, 1, 4'd1, 0, 8'd0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 8'd0,  0, 4'd0, 0, 8'd0, 0);
        for (int k = 0; k < 6; k++)
            tbl[6+k] = mk(0, 0, 1, 1, 8'(12 + k), 1, 4'(2 + k), 0, 8'd0, 0);
        tbl[12] = mk(0, 1, 1, 1, 8'd88, 0, 4'd0, 0, 8'd0, 0);
        tbl[13] = mk(0, 1, 0, 0, 8'd0,  0, 4'd0, 0, 8'd0, 0);
        tbl[14] = mk(0, 0, 1, 1, 8'd20, 1, 4'd8, 0, 8'd0, 0);
        for (int k = 1; k < 8; k++)
            tbl[14+k] = mk(0, 0, 1, 1, 8'(20 + k), 1, 4'(8 + k),
                           1, 8'(9 + k), 0);
        tbl[22] = mk(0, 0, 0, 0, 8'd0, 0, 4'd0, 1, 8'd17, 0);
        tbl[23] = mk(0, 0, 0, 0, 8'd0, 0, 4'd0, 0, 8'd0,  0);

        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        model_reset();

        // Reset, first two frames, gated strobes
        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].vs, tbl[i].href, tbl[i].ck, tbl[i].y,
                 1, tbl[i]);

        // Ping-pong third frame, back-to-back strobes
        frame(8, 0);
        frame(8, 0);
        // Short frame, then the unusable follower, then recovery
        frame(5, 0);
        frame(8, 0);
        frame(8, 0);
        frame(8, 0);
        // Overlong frames
        frame(9, 0);
        frame(8, 0);
        frame(10, 1);
        frame(8, 0);
        frame(8, 0);

        // Mid-frame reset at pixel 3 of a valid reference frame
        step(0, 1, 0, 0, 8'd0, 0, nul);
        step(0, 0, 0, 0, 8'd0, 0, nul);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'($urandom), 0, nul);
        step(1, 0, 1, 1, 8'd55, 0, nul);
        step(0, 0, 1, 1, 8'd56, 0, nul);
        idle(2);
        frame(8, 0);
        frame(8, 0);
        frame(8, 0);

        // Random frames, occasional resets
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 14) == 0) begin
                step(1, 1'($urandom_range(0, 1)), 1, 1, 8'($urandom), 0, nul);
            end
            if ($urandom_range(0, 3) != 0) frame(8, 1);
            else frame($urandom_range(2, 10), 1);
        end
        step(0, 1, 0, 0, 8'd0, 0, nul);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
